// File: rtl/fp_mul_sequencer.sv
// Sequenced IEEE-754 multiplier: one-cycle special-case resolution, otherwise shift-add
// mantissa multiply, normalize, round-to-nearest-even. Define FP_MUL_RADIX4_EN for 2 bits/cycle.
module fp_mul_sequencer #(
  parameter bit IS_DOUBLE  = 1'b0,
  parameter int EXP_WIDTH  = IS_DOUBLE ? 11 : 8,
  parameter int MANT_WIDTH = IS_DOUBLE ? 52 : 23
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]     op1,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]     op2,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_WIDTH+MANT_WIDTH:0]     result,
  output logic [3:0]                        flags
);
  localparam int W  = EXP_WIDTH + MANT_WIDTH + 1;
  localparam int N  = MANT_WIDTH + 1;
  localparam int PW = 2 * N;
  localparam int XW = EXP_WIDTH + 2;
  localparam int CW = $clog2(MANT_WIDTH + 2);
`ifdef FP_MUL_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [CW-1:0]        CNT_LAST = CW'(MANT_WIDTH + 1 - STEP);
  localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX     = XW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [XW-1:0] EZERO    = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]           op1_q, op1_d, op2_q, op2_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic [PW-1:0]          mcand_q, mcand_d, acc_q, acc_d;
  logic [N-1:0]           mplier_q, mplier_d;
  logic [W-1:0]           result_q, result_d;
  logic [3:0]             flags_q, flags_d;

  // Classification works on the registered operands; exponent 0 means zero (denormals flushed).
  logic [EXP_WIDTH-1:0]  e1, e2;
  logic                  nan1, nan2, inf1, inf2, zero1, zero2, sgn, special;
  logic [W-1:0]          spec_res;
  logic [3:0]            spec_flg;

  assign e1    = op1_q[W-2:MANT_WIDTH];
  assign e2    = op2_q[W-2:MANT_WIDTH];
  assign nan1  = (&e1) &  (|op1_q[MANT_WIDTH-1:0]);
  assign nan2  = (&e2) &  (|op2_q[MANT_WIDTH-1:0]);
  assign inf1  = (&e1) & ~(|op1_q[MANT_WIDTH-1:0]);
  assign inf2  = (&e2) & ~(|op2_q[MANT_WIDTH-1:0]);
  assign zero1 = (e1 == '0);
  assign zero2 = (e2 == '0);
  assign sgn   = op1_q[W-1] ^ op2_q[W-1];
  assign special = nan1 | nan2 | inf1 | inf2 | zero1 | zero2;

  always_comb begin
    spec_res = {sgn, {(W-1){1'b0}}};
    spec_flg = 4'b0000;
    if (nan1 | nan2) begin
      spec_res = QNAN;
    end else if ((inf1 & zero2) | (zero1 & inf2)) begin
      spec_res = QNAN;
      spec_flg = 4'b1000;
    end else if (inf1 | inf2) begin
      spec_res = {sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end
  end

  // Partial product for this iteration.
  logic [PW-1:0] pp;
`ifdef FP_MUL_RADIX4_EN
  assign pp = (mplier_q[0] ? mcand_q : '0) + (mplier_q[1] ? {mcand_q[PW-2:0], 1'b0} : '0);
`else
  assign pp = mplier_q[0] ? mcand_q : '0;
`endif

  // Normalize / round datapath.
  logic                 msb, guard, sticky, rnd, carry, ovf, unf;
  logic [PW-2:0]        prod_n;
  logic [N-1:0]         mant;
  logic [N:0]           mant_r;
  logic [MANT_WIDTH-1:0] frac;
  logic signed [XW-1:0] e_n;
  logic [W-1:0]         norm_res;
  logic [3:0]           norm_flg;

  always_comb begin
    msb    = acc_q[PW-1];
    prod_n = msb ? acc_q[PW-1:1] : acc_q[PW-2:0];
    mant   = prod_n[2*MANT_WIDTH:MANT_WIDTH];
    guard  = prod_n[MANT_WIDTH-1];
    sticky = (|prod_n[MANT_WIDTH-2:0]) | (msb & acc_q[0]);
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {{N{1'b0}}, rnd};
    carry  = mant_r[N];
    frac   = carry ? mant_r[MANT_WIDTH:1] : mant_r[MANT_WIDTH-1:0];
    e_n    = exp_q + XW'(msb) + XW'(carry);
    ovf    = (e_n >= EMAX);
    unf    = (e_n <= EZERO);
    if (ovf) begin
      norm_res = {sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      norm_flg = 4'b0101;
    end else if (unf) begin
      norm_res = {sgn, {(W-1){1'b0}}};
      norm_flg = 4'b0011;
    end else begin
      norm_res = {sgn, e_n[EXP_WIDTH-1:0], frac};
      norm_flg = {3'b000, guard | sticky};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: if (in_valid) begin
        op1_d    = op1;
        op2_d    = op2;
        exp_d    = XW'(op1[W-2:MANT_WIDTH]) + XW'(op2[W-2:MANT_WIDTH]) - BIAS;
        mcand_d  = {{N{1'b0}}, 1'b1, op1[MANT_WIDTH-1:0]};
        mplier_d = {1'b1, op2[MANT_WIDTH-1:0]};
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = MUL;
      end
      MUL: if (special) begin
        result_d = spec_res;
        flags_d  = spec_flg;
        state_d  = DONE;
      end else begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + CW'(STEP);
        if (cnt_q >= CNT_LAST) state_d = NORM;
      end
      NORM: begin
        result_d = norm_res;
        flags_d  = norm_flg;
        state_d  = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Scoreboard bench for fp_mul_sequencer (binary32): directed vectors, latency,
// backpressure hold, back-to-back issue and mid-multiply reset.
module tb_fp_mul_sequencer;
`ifdef FP_MUL_RADIX4_EN
  localparam int LAT_N = 13;
`else
  localparam int LAT_N = 25;
`endif
  localparam int LAT_S = 1;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] op1 = '0, op2 = '0;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fp_mul_sequencer #(.IS_DOUBLE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare once per result, on the first cycle out_valid is seen.
  initial begin
    bit   seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !seen) begin
        seen = 1;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got %0h expected none", result);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_flags"}, {28'd0, flags}, {28'd0, e.flg});
          check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      if (!out_valid) seen = 0;
    end
  end

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] flg, input int lat);
    exp_t e;
    int   g = 0;
    while (!in_ready && g < 300) begin @(negedge clk); g++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_accept_timeout: got in_ready=0 expected 1", nm);
    end else begin
      op1 = a; op2 = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      e.name = nm; e.res = res; e.flg = flg; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || out_valid) && g < 300) begin @(negedge clk); g++; end
    if (g >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result",    result,             32'h0);
    check("rst_flags",     {28'd0, flags},     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue("mul_2x3",     32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, LAT_N); drain();
    issue("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, LAT_S); drain();
    issue("nan_x_one",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, LAT_S); drain();
    issue("overflow",    32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, LAT_N); drain();
    issue("underflow",   32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, LAT_N); drain();
    issue("rne_sticky",  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, LAT_N); drain();
    issue("neg_x_denorm",32'hBF800000, 32'h00000001, 32'h80000000, 4'b0000, LAT_S); drain();
    issue("m15_x_m15",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, LAT_N); drain();
    issue("ninf_x_two",  32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, LAT_S); drain();
    issue("max_mant_sq", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, LAT_N); drain();

    // Backpressure: result must hold in DONE with in_ready low.
    out_ready = 1'b0;
    issue("hold_2x3", 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, LAT_N);
    g = 0;
    while (!out_valid && g < 100) begin @(negedge clk); g++; end
    repeat (5) begin
      @(negedge clk);
      check("hold_result",    result,             32'h40C00000);
      check("hold_flags",     {28'd0, flags},     32'd0);
      check("hold_in_ready",  {31'd0, in_ready},  32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready",  {31'd0, in_ready},  32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    issue("b2b_m15", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, LAT_N);
    drain();

    // Reset during the multiply: nothing may be emitted.
    issue("aborted", 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, LAT_N);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result",    result,             32'h0);
    check("abort_in_ready",  {31'd0, in_ready},  32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_flags",     {28'd0, flags},     32'd0);
    check("post_rst_in_ready",  {31'd0, in_ready},  32'd1);
    issue("after_rst", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, LAT_N);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
